// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver that turns single-byte ASCII commands into CPU control strobes:
// step ('s'/'S'), stretched reset request ('r'/'R') and a hex-digit user data word.
module uart_cmd_rx #(
    parameter int unsigned CLK_HZ           = 50000000,
    parameter int unsigned BAUD             = 115200,
    parameter int unsigned N                = 4,
    parameter int unsigned RST_PULSE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_in,
    output logic         step_pulse,
    output logic         reset_req,
    output logic [N-1:0] user_data,
    output logic         data_valid,
    output logic         frame_err,
    output logic [7:0]   last_byte
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned RW           = $clog2(RST_PULSE_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic            rx_meta;
    logic            rx_s;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            byte_done;
    logic [RW-1:0]   rst_cnt;
    logic [RW-1:0]   rst_nxt;
    logic            is_step;
    logic            is_rst;
    logic            is_hex;
    logic [3:0]      hex_val;

    // Command decode of the byte captured by the last good frame
    always_comb begin
        is_step = (shift == 8'h73) || (shift == 8'h53);
        is_rst  = (shift == 8'h72) || (shift == 8'h52);
        is_hex  = 1'b0;
        hex_val = 4'd0;
        if (shift >= 8'h30 && shift <= 8'h39) begin
            is_hex  = 1'b1;
            hex_val = 4'(shift - 8'h30);
        end else if (shift >= 8'h41 && shift <= 8'h46) begin
            is_hex  = 1'b1;
            hex_val = 4'(shift - 8'h37);
        end else if (shift >= 8'h61 && shift <= 8'h66) begin
            is_hex  = 1'b1;
            hex_val = 4'(shift - 8'h57);
        end
    end

    // Reset-request stretcher: a new 'r' reloads, otherwise count down to zero
    always_comb begin
        rst_nxt = rst_cnt;
        if (byte_done && is_rst) begin
            rst_nxt = RW'(RST_PULSE_CYCLES);
        end else if (rst_cnt != '0) begin
            rst_nxt = rst_cnt - RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            state      <= WAIT_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_done  <= 1'b0;
            rst_cnt    <= '0;
            reset_req  <= 1'b0;
            step_pulse <= 1'b0;
            user_data  <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            last_byte  <= '0;
        end else begin
            rx_meta    <= rx_in;
            rx_s       <= rx_meta;
            byte_done  <= 1'b0;
            frame_err  <= 1'b0;
            step_pulse <= 1'b0;
            data_valid <= 1'b0;
            rst_cnt    <= rst_nxt;
            reset_req  <= (rst_nxt != '0);

            if (byte_done) begin
                last_byte  <= shift;
                step_pulse <= is_step;
                if (is_hex) begin
                    user_data  <= N'(hex_val);
                    data_valid <= 1'b1;
                end
            end

            // Receive FSM: start validated at mid-bit, data and stop sampled at bit centres
            case (state)
                WAIT_IDLE: begin
                    if (rx_s) state <= IDLE;
                end
                IDLE: begin
                    baud_cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt       <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) state <= STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            byte_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed plus randomized bench for uart_cmd_rx at 16 clocks per bit; a second
// instance with a long reset stretch exercises reset_req reload on back-to-back 'r'.
module tb_uart_cmd_rx;

    localparam int unsigned CLK_HZ    = 1600000;
    localparam int unsigned BAUD      = 100000;
    localparam int unsigned CPB       = CLK_HZ / BAUD;
    localparam int unsigned N         = 4;
    localparam int unsigned RST_SHORT = 16;
    localparam int unsigned RST_LONG  = 165;
    // start edge -> decode: 2 sync + 1 detect + half bit + 8 data + stop + 1 decode
    localparam int LAT = 2 + 1 + int'(CPB / 2) + 9 * int'(CPB) + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx_in = 1'b1;
    logic         step_pulse, reset_req, data_valid, frame_err;
    logic [N-1:0] user_data;
    logic [7:0]   last_byte;
    logic         l_step_pulse, l_reset_req, l_data_valid, l_frame_err;
    logic [N-1:0] l_user_data;
    logic [7:0]   l_last_byte;

    uart_cmd_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .N(N), .RST_PULSE_CYCLES(RST_SHORT)) dut (
        .clk(clk), .reset(reset), .rx_in(rx_in),
        .step_pulse(step_pulse), .reset_req(reset_req), .user_data(user_data),
        .data_valid(data_valid), .frame_err(frame_err), .last_byte(last_byte)
    );

    uart_cmd_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .N(N), .RST_PULSE_CYCLES(RST_LONG)) dut_long (
        .clk(clk), .reset(reset), .rx_in(rx_in),
        .step_pulse(l_step_pulse), .reset_req(l_reset_req), .user_data(l_user_data),
        .data_valid(l_data_valid), .frame_err(l_frame_err), .last_byte(l_last_byte)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder sampled mid-cycle
    int n_step = 0, n_dv = 0, n_fe = 0, n_rr = 0, n_lrr = 0, n_lstb = 0;
    int step_cyc = -1, dv_cyc = -1, rr_rise = -1, rr_fall = -1, lrr_rise = -1, lrr_fall = -1;
    logic rr_q = 1'b0, lrr_q = 1'b0;
    always @(negedge clk) begin
        if (step_pulse) begin n_step <= n_step + 1; step_cyc <= cyc; end
        if (data_valid) begin n_dv <= n_dv + 1; dv_cyc <= cyc; end
        if (frame_err) n_fe <= n_fe + 1;
        if (reset_req && !rr_q) begin n_rr <= n_rr + 1; rr_rise <= cyc; end
        if (!reset_req && rr_q) rr_fall <= cyc;
        if (l_reset_req && !lrr_q) begin n_lrr <= n_lrr + 1; lrr_rise <= cyc; end
        if (!l_reset_req && lrr_q) lrr_fall <= cyc;
        if (l_step_pulse || l_data_valid || l_frame_err) n_lstb <= n_lstb + 1;
        rr_q  <= reset_req;
        lrr_q <= l_reset_req;
    end

    int chk = 0, err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one 8N1 frame; call right after a posedge, returns right after a posedge
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t0);
        #1;
        t0    = cyc;
        rx_in = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx_in = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rx_in = stop_bit;
        repeat (CPB) @(posedge clk);
    endtask

    // Reference: value of a hex-digit command, or -1 when the byte is not one
    function automatic int hex_of(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 65 + 10;
        if (b >= 8'h61 && b <= 8'h66) return int'(b) - 97 + 10;
        return -1;
    endfunction

    function automatic bit is_step_cmd(input logic [7:0] b);
        return b == 8'h73 || b == 8'h53;
    endfunction

    function automatic bit is_rst_cmd(input logic [7:0] b);
        return b == 8'h72 || b == 8'h52;
    endfunction

    initial begin
        int t0, t1, s_step, s_dv, s_fe, s_rr, s_lrr, s_lstb, exp_ud, hv;
        logic [7:0] exp_lb, b;
        logic [7:0] dir_bytes [3];
        string hexchars;

        hexchars = "0123456789abcdefABCDEF";
        exp_ud = 0;
        exp_lb = 8'h00;

        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_step", 32'(step_pulse), 32'd0);
        check("rst_rreq", 32'(reset_req), 32'd0);
        check("rst_udata", 32'(user_data), 32'd0);
        check("rst_dvalid", 32'(data_valid), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_lbyte", 32'(last_byte), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);

        // 's' gives one step pulse at the expected cycle
        s_step = n_step; s_dv = n_dv; s_rr = n_rr;
        send_frame(8'h73, 1'b1, t0);
        repeat (20) @(posedge clk);
        check("s_count", n_step - s_step, 1);
        check("s_time", step_cyc, t0 + LAT);
        check("s_no_dv", n_dv - s_dv, 0);
        check("s_no_rr", n_rr - s_rr, 0);
        check("s_lbyte", 32'(last_byte), 32'h73);
        exp_lb = 8'h73;

        // Hex digits 'A', '7', 'f'
        dir_bytes[0] = 8'h41; dir_bytes[1] = 8'h37; dir_bytes[2] = 8'h66;
        for (int i = 0; i < 3; i++) begin
            s_step = n_step; s_dv = n_dv; s_rr = n_rr;
            @(posedge clk);
            send_frame(dir_bytes[i], 1'b1, t0);
            repeat (20) @(posedge clk);
            exp_ud = hex_of(dir_bytes[i]);
            check("hex_dv", n_dv - s_dv, 1);
            check("hex_time", dv_cyc, t0 + LAT);
            check("hex_udata", 32'(user_data), 32'(exp_ud));
            check("hex_no_step", n_step - s_step, 0);
            check("hex_no_rr", n_rr - s_rr, 0);
        end
        exp_lb = 8'h66;

        // 'r' stretches reset_req for RST_SHORT cycles
        s_rr = n_rr;
        @(posedge clk);
        send_frame(8'h72, 1'b1, t0);
        repeat (30) @(posedge clk);
        check("r_count", n_rr - s_rr, 1);
        check("r_rise", rr_rise, t0 + LAT);
        check("r_width", rr_fall - rr_rise, int'(RST_SHORT));
        exp_lb = 8'h72;

        // Randomized command stream against the reference decode
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 3))
                0: b = hexchars[$urandom_range(0, 21)];
                1: b = ($urandom_range(0, 1) != 0) ? 8'h73 : 8'h53;
                2: b = ($urandom_range(0, 1) != 0) ? 8'h72 : 8'h52;
                default: b = 8'($urandom_range(0, 255));
            endcase
            s_step = n_step; s_dv = n_dv; s_rr = n_rr;
            repeat ($urandom_range(1, 20)) @(posedge clk);
            send_frame(b, 1'b1, t0);
            repeat (24) @(posedge clk);
            hv = hex_of(b);
            if (hv >= 0) exp_ud = hv;
            exp_lb = b;
            check("rnd_step", n_step - s_step, int'(is_step_cmd(b)));
            check("rnd_dv", n_dv - s_dv, int'(hv >= 0));
            check("rnd_rr", n_rr - s_rr, int'(is_rst_cmd(b)));
            check("rnd_udata", 32'(user_data), 32'(exp_ud));
            check("rnd_lbyte", 32'(last_byte), 32'(exp_lb));
        end

        // Back-to-back 'r': long instance reloads at 6 and stays high throughout
        repeat (200) @(posedge clk);
        s_rr = n_rr; s_lrr = n_lrr; s_lstb = n_lstb;
        @(posedge clk);
        send_frame(8'h72, 1'b1, t0);
        send_frame(8'h72, 1'b1, t1);
        repeat (200) @(posedge clk);
        exp_lb = 8'h72;
        check("rr2_long_count", n_lrr - s_lrr, 1);
        check("rr2_long_rise", lrr_rise, t0 + LAT);
        check("rr2_long_fall", lrr_fall, t1 + LAT + int'(RST_LONG));
        check("rr2_short_count", n_rr - s_rr, 2);
        check("rr2_short_fall", rr_fall, t1 + LAT + int'(RST_SHORT));
        check("rr2_long_lbyte", 32'(l_last_byte), 32'h72);
        check("rr2_long_udata", 32'(l_user_data), 32'(exp_ud));
        check("rr2_long_nostb", n_lstb - s_lstb, 0);

        // Bad stop bit, line held low, then a good 's'
        s_step = n_step; s_fe = n_fe;
        @(posedge clk);
        send_frame(8'h73, 1'b0, t0);
        repeat (2 * CPB) @(posedge clk);
        #1 rx_in = 1'b1;
        repeat (CPB) @(posedge clk);
        check("ferr_count", n_fe - s_fe, 1);
        check("ferr_no_step", n_step - s_step, 0);
        check("ferr_lbyte", 32'(last_byte), 32'(exp_lb));
        send_frame(8'h73, 1'b1, t0);
        repeat (20) @(posedge clk);
        exp_lb = 8'h73;
        check("ferr_next_step", n_step - s_step, 1);
        check("ferr_next_time", step_cyc, t0 + LAT);
        check("ferr_no_more_fe", n_fe - s_fe, 1);

        // Short low glitch on an idle line, then 'S'
        s_step = n_step; s_dv = n_dv; s_fe = n_fe; s_rr = n_rr;
        @(posedge clk);
        #1 rx_in = 1'b0;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 rx_in = 1'b1;
        repeat (CPB) @(posedge clk);
        check("glitch_none", (n_step - s_step) + (n_dv - s_dv) + (n_fe - s_fe) + (n_rr - s_rr), 0);
        check("glitch_lbyte", 32'(last_byte), 32'(exp_lb));
        send_frame(8'h53, 1'b1, t0);
        repeat (20) @(posedge clk);
        exp_lb = 8'h53;
        check("glitch_S_step", n_step - s_step, 1);
        check("glitch_S_time", step_cyc, t0 + LAT);
        check("glitch_S_lbyte", 32'(last_byte), 32'h53);

        // One-cycle reset inside the data bits of 's'
        s_step = n_step; s_dv = n_dv;
        @(posedge clk);
        fork
            send_frame(8'h73, 1'b1, t0);
            begin
                repeat (138) @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
            end
        join
        repeat (20) @(posedge clk);
        exp_lb = 8'h00;
        exp_ud = 0;
        check("mrst_no_step", n_step - s_step, 0);
        check("mrst_no_dv", n_dv - s_dv, 0);
        check("mrst_lbyte", 32'(last_byte), 32'(exp_lb));
        check("mrst_udata", 32'(user_data), 32'(exp_ud));
        send_frame(8'h73, 1'b1, t0);
        repeat (20) @(posedge clk);
        check("mrst_next_step", n_step - s_step, 1);
        check("mrst_next_time", step_cyc, t0 + LAT);
        check("mrst_next_lbyte", 32'(last_byte), 32'h73);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
